// File: rtl/div_pkg.sv
// Shared state encodings, handshake values and constants for the radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic        RstEnable         = 1'b1;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic [5:0]  DivIters          = 6'd32;

  // Magnitude of an operand; only negative values in signed mode are complemented.
  function automatic logic [31:0] abs_op(input logic [31:0] op, input logic sgn);
    return (sgn && op[31]) ? (~op + 32'd1) : op;
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle 32-bit radix-2 restoring divider (DIV/DIVU), 33-cycle latency.
// Optional DIV_ZERO_FLAG_EN adds div_zero_o, raised with ready_o for a zero divisor.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic        div_zero_o
`endif
);

  div_state_t  state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [64:0] dividend, dividend_nxt;
  logic [31:0] divisor, divisor_nxt;
  logic        sign1, sign1_nxt, sign2, sign2_nxt, sdiv, sdiv_nxt;
  logic [63:0] result_nxt;
  logic        ready_nxt;
  logic [32:0] tmp;
  logic [31:0] quo, rem;
  logic        go;

  assign go = (start_i == DivStart) && !annul_i;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) state <= DivFree;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DivFree:   if (go) state_nxt = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
      DivByZero: state_nxt = DivEnd;
      DivOn: begin
        // Annul wins over both iterating and finishing.
        if (annul_i)               state_nxt = DivFree;
        else if (cnt == DivIters)  state_nxt = DivEnd;
      end
      DivEnd:    if (start_i == DivStop) state_nxt = DivFree;
      default:   state_nxt = DivFree;
    endcase
  end

  always_comb begin
    tmp          = {1'b0, dividend[63:32]} - {1'b0, divisor};
    quo          = (sdiv && (sign1 ^ sign2)) ? (~dividend[31:0] + 32'd1) : dividend[31:0];
    rem          = (sdiv && sign1) ? (~dividend[64:33] + 32'd1) : dividend[64:33];
    cnt_nxt      = cnt;
    dividend_nxt = dividend;
    divisor_nxt  = divisor;
    sign1_nxt    = sign1;
    sign2_nxt    = sign2;
    sdiv_nxt     = sdiv;
    result_nxt   = result_o;
    ready_nxt    = ready_o;
    case (state)
      DivFree: begin
        result_nxt = 64'h0;
        ready_nxt  = DivResultNotReady;
        if (go) begin
          cnt_nxt      = '0;
          dividend_nxt = {ZeroWord, abs_op(opdata1_i, signed_div_i), 1'b0};
          divisor_nxt  = abs_op(opdata2_i, signed_div_i);
          sign1_nxt    = opdata1_i[31];
          sign2_nxt    = opdata2_i[31];
          sdiv_nxt     = signed_div_i;
        end
      end
      DivByZero: begin
        result_nxt = 64'h0;
        ready_nxt  = DivResultReady;
      end
      DivOn: begin
        if (annul_i) begin
          cnt_nxt = '0;
        end else if (cnt != DivIters) begin
          // Restore by keeping the old partial remainder when the trial subtract borrows.
          if (tmp[32]) dividend_nxt = {dividend[63:0], 1'b0};
          else         dividend_nxt = {tmp[31:0], dividend[31:0], 1'b1};
          cnt_nxt = cnt + 6'd1;
        end else begin
          result_nxt = {rem, quo};
          ready_nxt  = DivResultReady;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          result_nxt = 64'h0;
          ready_nxt  = DivResultNotReady;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      sdiv     <= 1'b0;
      result_o <= 64'h0;
      ready_o  <= DivResultNotReady;
    end else begin
      cnt      <= cnt_nxt;
      dividend <= dividend_nxt;
      divisor  <= divisor_nxt;
      sign1    <= sign1_nxt;
      sign2    <= sign2_nxt;
      sdiv     <= sdiv_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst == RstEnable)                             div_zero_o <= 1'b0;
    else if (state == DivByZero)                      div_zero_o <= 1'b1;
    else if (state == DivEnd && start_i == DivStop)   div_zero_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: expectations queued at launch, checked when ready_o rises.
module tb_div;

  logic        clk = 1'b0;
  logic        rst, signed_div_i, start_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero_o;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp;

  always #5 clk = ~clk;

  div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
`ifdef DIV_ZERO_FLAG_EN
    , .div_zero_o(div_zero_o)
`endif
  );

  // Reference: 64-bit integer divide, truncating toward zero; zero divisor yields 0.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    opdata1_i = a; opdata2_i = b; signed_div_i = sgn; start_i = 1'b1;
    exp_q.push_back(model(a, b, sgn));
  endtask

  // Returns number of edges after the start edge until ready_o is seen (bounded).
  task automatic wait_ready(input bit e0_done, output int n);
    if (!e0_done) step();
    n = 0;
    do begin step(); n++; end while (!ready_o && n < 100);
  endtask

  task automatic pop_exp();
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    else exp = 64'hxxxx_xxxx_xxxx_xxxx;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    step(); step();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      failures++; $display("FAIL reset_outputs ready=%b result=%h required ready=0 result=0", ready_o, result_o);
    end
    rst = 1'b0;
    n = 0;
    step();
    checks++;
    if (ready_o !== 1'b0) begin
      failures++; $display("FAIL reset_idle ready=%b required 0", ready_o);
    end
  endtask

  task automatic test_divu_basic();
    int n;
    launch(32'd100, 32'd7, 1'b0);
    wait_ready(1'b0, n);
    pop_exp();
    checks++;
    if (n !== 33) begin failures++; $display("FAIL divu_latency got=%0d required=33", n); end
    checks++;
    if (result_o !== exp) begin failures++; $display("FAIL divu_result got=%h required=%h", result_o, exp); end
    checks++;
    if (result_o !== 64'h00000002_0000000E) begin
      failures++; $display("FAIL divu_const got=%h required=000000020000000e", result_o);
    end
    step(); step();
    checks++;
    if (ready_o !== 1'b1 || result_o !== exp) begin
      failures++; $display("FAIL divu_hold ready=%b result=%h required ready=1 result=%h", ready_o, result_o, exp);
    end
    start_i = 1'b0; step();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      failures++; $display("FAIL divu_release ready=%b result=%h required 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_signed();
    int n;
    logic [63:0] consts[2];
    logic [31:0] a[2], b[2];
    a = '{32'hFFFF_FFF9, 32'h0000_0007};
    b = '{32'h0000_0002, 32'hFFFF_FFFE};
    consts = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD};
    for (int i = 0; i < 2; i++) begin
      launch(a[i], b[i], 1'b1);
      wait_ready(1'b0, n);
      pop_exp();
      checks++;
      if (result_o !== exp || result_o !== consts[i]) begin
        failures++; $display("FAIL signed_%0d got=%h required=%h", i, result_o, consts[i]);
      end
      start_i = 1'b0; step();
    end
  endtask

  task automatic test_div_zero();
    int n;
    for (int i = 0; i < 2; i++) begin
      launch(i == 0 ? 32'h1234_5678 : 32'h8000_0000, 32'h0, i[0]);
      wait_ready(1'b0, n);
      pop_exp();
      checks++;
      if (n !== 1) begin failures++; $display("FAIL divzero_latency_%0d got=%0d required=1", i, n); end
      checks++;
      if (result_o !== exp) begin failures++; $display("FAIL divzero_result_%0d got=%h required=%h", i, result_o, exp); end
`ifdef DIV_ZERO_FLAG_EN
      checks++;
      if (div_zero_o !== 1'b1) begin failures++; $display("FAIL divzero_flag_%0d got=%b required=1", i, div_zero_o); end
`endif
      start_i = 1'b0; step();
`ifdef DIV_ZERO_FLAG_EN
      checks++;
      if (div_zero_o !== 1'b0) begin failures++; $display("FAIL divzero_flag_clr_%0d got=%b required=0", i, div_zero_o); end
`endif
    end
  endtask

  task automatic test_annul();
    int n;
    bit seen;
    launch(32'hDEAD_BEEF, 32'd3, 1'b0);
    void'(exp_q.pop_back());
    step();
    for (int i = 0; i < 10; i++) step();
    annul_i = 1'b1; start_i = 1'b0;
    step();
    annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL annul_no_ready got=%b required=0", seen); end
    launch(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_ready(1'b0, n);
    pop_exp();
    checks++;
    if (n !== 33 || result_o !== exp) begin
      failures++; $display("FAIL annul_fresh lat=%0d result=%h required lat=33 result=%h", n, result_o, exp);
    end
    start_i = 1'b0; step();
  endtask

  task automatic test_boundary();
    int n;
    logic [31:0] a[3], b[3];
    logic        s[3];
    a = '{32'h8000_0000, 32'h8000_0000, 32'h0};
    b = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9};
    s = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      launch(a[i], b[i], s[i]);
      wait_ready(1'b0, n);
      pop_exp();
      checks++;
      if (n !== 33 || result_o !== exp) begin
        failures++; $display("FAIL boundary_%0d lat=%0d result=%h required lat=33 result=%h", i, n, result_o, exp);
      end
      start_i = 1'b0; step();
    end
  endtask

  task automatic test_reset_mid();
    int n;
    launch(32'd1000, 32'd3, 1'b0);
    step();
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1; step();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      failures++; $display("FAIL rst_mid ready=%b result=%h required 0/0", ready_o, result_o);
    end
    rst = 1'b0;
    wait_ready(1'b0, n);
    pop_exp();
    checks++;
    if (n !== 33 || result_o !== exp) begin
      failures++; $display("FAIL rst_relaunch lat=%0d result=%h required lat=33 result=%h", n, result_o, exp);
    end
    start_i = 1'b0; step();
  endtask

  task automatic test_back_to_back();
    int n;
    launch(32'd50000, 32'd123, 1'b0);
    step();
    opdata1_i = 32'h0; opdata2_i = 32'h0; signed_div_i = 1'b1;
    wait_ready(1'b1, n);
    pop_exp();
    checks++;
    if (n !== 33 || result_o !== exp) begin
      failures++; $display("FAIL operand_stable lat=%0d result=%h required lat=33 result=%h", n, result_o, exp);
    end
    start_i = 1'b0; step();
    for (int i = 0; i < 4; i++) begin
      launch($urandom, $urandom_range(1, 32'h7FFF_FFFF) ^ (i[0] ? 32'h8000_0000 : 32'h0), i[1]);
      wait_ready(1'b0, n);
      pop_exp();
      checks++;
      if (n !== 33 || result_o !== exp) begin
        failures++; $display("FAIL b2b_%0d lat=%0d result=%h required lat=33 result=%h", i, n, result_o, exp);
      end
      start_i = 1'b0; step();
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_annul();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
